regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter sharing the register file's single write port between the execute stage and a multi-cycle load unit. Execute results normally take the port and load results queue in a small FIFO that drains on idle write-port cycles. A starvation counter forces a drain when execute has held the port for too long. A pending-write mask lets the hazard unit stall consumers of not-yet-written registers.

## Interface
- XLEN, 32, data width.
- DEPTH, 4, load FIFO entries (power of two, at least 2).
- STARVE_LIMIT, 8, consecutive non-drain cycles with a non-empty FIFO before a forced drain (at least 1).
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  execute result accepted this cycle.
- ex_rd  in  5  execute destination register.
- ex_data  in  XLEN  execute result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load result accepted this cycle.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load result.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  5  register file write address (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- pending_mask  out  32  bit i set when a write to register i is queued or sitting in the output register.
- fifo_full  out  1  load FIFO holds DEPTH entries.

## Operation
- A transfer occurs when valid and ready are both high in the same cycle.
- A transfer with rd = 0 is accepted and discarded. It is never enqueued or written.
- Per-cycle selection, in priority order:
  - 1. Forced drain: starve_cnt == STARVE_LIMIT and FIFO non-empty. The FIFO head is issued and ex_ready = 0.
  - 2. Execute: ex_valid with ex_rd != 0 is issued and ex_ready = 1.
  - 3. Drain: FIFO non-empty and the port is otherwise free. This includes the cycle of an accepted ex_rd = 0 transfer. The FIFO head is issued.
  - 4. Bypass: only with the configuration macro defined; see Configuration.
- ex_ready = 1 in every cycle except forced-drain cycles and reset.
- ld_ready = (count < DEPTH). Same-cycle pop and push at full is not allowed.
- When a pop and a push happen in the same cycle, count is unchanged.
- Issue: rf_we, rf_waddr and rf_wdata are loaded on the next edge. In a cycle with nothing issued, rf_we is loaded with 0 and rf_waddr/rf_wdata hold their values.
- starve_cnt:
  - Cleared on a drain or when the FIFO is empty.
  - Otherwise increments each cycle, saturating at STARVE_LIMIT.
- pending_mask is the OR over all valid FIFO entries of (1 << rd), plus (1 << rf_waddr) when rf_we = 1. It is combinational from registered state.
- Ordering: loads write in acceptance order. Ordering between execute and load writes to the same rd is enforced upstream using pending_mask; the arbiter does not reorder.

## Timing
- Execute write latency is 1. Accepted in cycle N, rf_we = 1 in cycle N+1, and the register file commits at the end of N+1.
- Load write latency is at least 2 without bypass: enqueue at N, earliest issue at N+1, rf_we at N+2.
- Worst-case load wait behind continuous execute traffic: STARVE_LIMIT + 1 cycles from reaching the FIFO head to issue.
- Reset (rst_n low at a posedge) sets:
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - FIFO empty, count = 0, starve_cnt = 0, pending_mask = 0, fifo_full = 0.
- While rst_n is low, ex_ready = 0 and ld_ready = 0.
- Reset mid-operation discards all queued loads and any registered write.

## Configuration
- REGFILE_WB_ARB_BYPASS_EN defined:
  - A load with ld_rd != 0 goes straight to the output register when the FIFO is empty, no execute issue occurs this cycle, and no forced drain occurs this cycle.
  - Load latency in that case is 1.
- REGFILE_WB_ARB_BYPASS_EN undefined:
  - Every accepted load with rd != 0 is enqueued.
  - Load latency is at least 2.

## Test plan
- Reset with garbage inputs, then idle: all outputs are 0, ld_ready = 1 and ex_ready = 1 one cycle after rst_n rises.
- Execute rd = 5, data 0xDEADBEEF, in cycle N: rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF in N+1. pending_mask = 0x20 during N+1 only.
- Loads to rd = 3, 4, 7, 9 plus a fifth load, with ex_valid held high:
  - fifo_full = 1 and ld_ready = 0 for the fifth load.
  - After 8 blocked cycles, a forced drain issues rd = 3 with ex_ready = 0 for exactly one cycle.
- Execute rd = 0 in the same cycle the FIFO holds rd = 12: no write for rd = 0. rd = 12 issues and rf_waddr = 12 the next cycle.
- Load rd = 2, data 0x11, with an empty FIFO and no execute traffic:
  - Macro defined: rf_we in N+1.
  - Macro undefined: rf_we in N+2, and pending_mask bit 2 is set in N+1.
- rst_n asserted with 3 loads queued: the FIFO is emptied and pending_mask = 0. No write for any of the dropped loads appears after reset.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: execute and load handshakes plus register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending_mask;
  logic            fifo_full;

  modport master (
    output ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data,
    input  ex_ready, ld_ready, rf_we, rf_waddr, rf_wdata, pending_mask, fifo_full
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data,
    output ex_ready, ld_ready, rf_we, rf_waddr, rf_wdata, pending_mask, fifo_full
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between execute results and a load FIFO with starvation-forced drains.
// Define REGFILE_WB_ARB_BYPASS_EN to let loads skip an empty FIFO straight into the output register.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_FORCE,
    SEL_EX,
    SEL_DRAIN,
    SEL_BYPASS
  } sel_t;

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;

  sel_t            sel;
  logic            empty, forced, ex_xfer, ld_xfer, push, pop;
  logic [4:0]      iss_rd;
  logic [XLEN-1:0] iss_data;

  always_comb begin
    empty        = (count == '0);
    forced       = (starve == SW'(STARVE_LIMIT)) && !empty;
    bus.ex_ready = rst_n && !forced;
    bus.ld_ready = rst_n && (count < CW'(DEPTH));
    bus.fifo_full = (count == CW'(DEPTH));
    ex_xfer      = bus.ex_valid && bus.ex_ready;
    ld_xfer      = bus.ld_valid && bus.ld_ready;

    sel = SEL_NONE;
    if (forced)
      sel = SEL_FORCE;
    else if (ex_xfer && bus.ex_rd != 5'd0)
      sel = SEL_EX;
    else if (!empty)
      sel = SEL_DRAIN;
`ifdef REGFILE_WB_ARB_BYPASS_EN
    else if (ld_xfer && bus.ld_rd != 5'd0)
      sel = SEL_BYPASS;
`endif

    pop  = (sel == SEL_FORCE) || (sel == SEL_DRAIN);
    // rd = 0 loads are acknowledged but never stored
    push = ld_xfer && (bus.ld_rd != 5'd0) && (sel != SEL_BYPASS);

    iss_rd   = fifo_rd[head];
    iss_data = fifo_data[head];
    if (sel == SEL_EX) begin
      iss_rd   = bus.ex_rd;
      iss_data = bus.ex_data;
    end else if (sel == SEL_BYPASS) begin
      iss_rd   = bus.ld_rd;
      iss_data = bus.ld_data;
    end
  end

  always_comb begin
    bus.pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (vld[i])
        bus.pending_mask[fifo_rd[i]] = 1'b1;
    if (bus.rf_we)
      bus.pending_mask[bus.rf_waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      starve       <= '0;
      vld          <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      if (push) begin
        fifo_rd[tail]   <= bus.ld_rd;
        fifo_data[tail] <= bus.ld_data;
        vld[tail]       <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop || empty)
        starve <= '0;
      else if (starve != SW'(STARVE_LIMIT))
        starve <= starve + 1'b1;

      bus.rf_we <= (sel != SEL_NONE);
      if (sel != SEL_NONE) begin
        bus.rf_waddr <= iss_rd;
        bus.rf_wdata <= iss_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model and write scoreboard.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
  } wr_t;

  wr_t        mq[$];
  wr_t        sb[$];
  int         starve = 0;
  bit         m_we = 0;
  logic [4:0] m_waddr = '0;
  bit         mon_en = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides what the port must do this cycle.
  task automatic cycle(bit r, bit exv, logic [4:0] exrd, logic [XLEN-1:0] exd,
                       bit ldv, logic [4:0] ldrd, logic [XLEN-1:0] ldd);
    bit          exr, ldr, ex_iss, issued, popped, bypassed;
    int          size0;
    wr_t         w;
    logic [31:0] pm;
    @(negedge clk);
    rst_n        = r;
    bus.ex_valid = exv;
    bus.ex_rd    = exrd;
    bus.ex_data  = exd;
    bus.ld_valid = ldv;
    bus.ld_rd    = ldrd;
    bus.ld_data  = ldd;
    #1;
    if (!r) begin
      chk("ex_ready_in_reset", {63'd0, bus.ex_ready}, 64'd0);
      chk("ld_ready_in_reset", {63'd0, bus.ld_ready}, 64'd0);
      mq.delete();
      starve  = 0;
      m_we    = 0;
      m_waddr = '0;
      mon_en  = 1;
      return;
    end
    size0 = mq.size();
    exr   = !((starve == LIMIT) && (size0 > 0));
    ldr   = size0 < DEPTH;
    chk("ex_ready", {63'd0, bus.ex_ready}, {63'd0, exr});
    chk("ld_ready", {63'd0, bus.ld_ready}, {63'd0, ldr});
    chk("fifo_full", {63'd0, bus.fifo_full}, {63'd0, size0 == DEPTH});
    pm = '0;
    foreach (mq[i]) pm[mq[i].rd] = 1'b1;
    if (m_we) pm[m_waddr] = 1'b1;
    chk("pending_mask", {32'd0, bus.pending_mask}, {32'd0, pm});

    issued = 0; popped = 0; bypassed = 0;
    ex_iss = exv && exr && (exrd != 5'd0);
    if (ex_iss) begin
      w.rd = exrd; w.d = exd; issued = 1;
    end else if (size0 > 0) begin
      w = mq.pop_front(); issued = 1; popped = 1;
    end
`ifdef REGFILE_WB_ARB_BYPASS_EN
    else if (ldv && ldr && ldrd != 5'd0) begin
      w.rd = ldrd; w.d = ldd; issued = 1; bypassed = 1;
    end
`endif
    if (ldv && ldr && ldrd != 5'd0 && !bypassed) begin
      wr_t l;
      l.rd = ldrd; l.d = ldd;
      mq.push_back(l);
    end
    if (popped || size0 == 0) starve = 0;
    else if (starve < LIMIT) starve++;
    if (issued) begin
      sb.push_back(w);
      m_waddr = w.rd;
    end
    m_we = issued;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 5'd0, '0, 0, 5'd0, '0);
  endtask

  initial begin : monitor
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("rf_we", {63'd0, bus.rf_we}, {63'd0, sb.size() > 0});
        if (sb.size() > 0) begin
          w = sb.pop_front();
          if (bus.rf_we) begin
            chk("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, w.rd});
            chk("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, w.d});
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [4:0] lds [4];
    lds[0] = 5'd3; lds[1] = 5'd4; lds[2] = 5'd7; lds[3] = 5'd9;

    for (int i = 0; i < 3; i++)
      cycle(0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    @(posedge clk);
    #2;
    chk("reset_rf_waddr", {59'd0, bus.rf_waddr}, 64'd0);
    chk("reset_rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    chk("reset_pending", {32'd0, bus.pending_mask}, 64'd0);
    chk("reset_fifo_full", {63'd0, bus.fifo_full}, 64'd0);
    idle(2);

    cycle(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0);
    idle(3);

    for (int k = 0; k < 16; k++)
      cycle(1, 1, 5'(1 + (k % 30)), 32'h1000 + k, k < 6, (k < 4) ? lds[k] : 5'd10, 32'h2000 + k);
    idle(10);

    cycle(1, 1, 5'd1, 32'h0A, 1, 5'd12, 32'hC0C0);
    cycle(1, 1, 5'd0, 32'hBAD, 0, 5'd0, '0);
    idle(3);

    cycle(1, 0, 5'd0, '0, 1, 5'd2, 32'h11);
    idle(3);

    cycle(1, 1, 5'd6, 32'h60, 1, 5'd20, 32'h20);
    cycle(1, 1, 5'd7, 32'h70, 1, 5'd21, 32'h21);
    cycle(1, 1, 5'd8, 32'h80, 1, 5'd22, 32'h22);
    cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 199) != 0);
      cycle(r,
            $urandom_range(0, 99) < 70, 5'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31)), $urandom,
            $urandom_range(0, 99) < 50, 5'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31)), $urandom);
    end
    idle(20);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
